// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Optional macro ALU_SEQ_DIV_EN builds the divider; without it DIV returns C=0 with overflow set.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       SEL,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_HI,
  output logic             zero_flag,
  output logic             over_flow_flag,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_EQ  = 4'h8, OP_GT  = 4'h9, OP_LT  = 4'hA, OP_SHL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC, OP_ROL = 4'hD, OP_ROR = 4'hE, OP_PAS = 4'hF;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] c_q, c_hi_q;
  logic             zero_q, ovf_q, carry_q;
`ifdef ALU_SEQ_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   trial;
`endif

  logic [WIDTH:0]   add_w, sub_w, mul_sum;
  logic [WIDTH-1:0] s_c_d, s_hi_d, step_hi_d, step_lo_d;
  logic             s_ovf_d, s_carry_d;

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign C              = c_q;
  assign C_HI           = c_hi_q;
  assign zero_flag      = zero_q;
  assign over_flow_flag = ovf_q;
  assign carry_out      = carry_q;

  always_comb begin
    add_w     = {1'b0, A} + {1'b0, B};
    sub_w     = {1'b0, A} - {1'b0, B};
    s_c_d     = '0;
    s_hi_d    = '0;
    s_ovf_d   = 1'b0;
    s_carry_d = 1'b0;
    case (SEL)
      OP_ADD: begin
        s_c_d     = add_w[WIDTH-1:0];
        s_carry_d = add_w[WIDTH];
        s_ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        s_c_d     = sub_w[WIDTH-1:0];
        s_carry_d = sub_w[WIDTH];
        s_ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      // Only the divide-by-zero case of DIV resolves here; B!=0 goes iterative.
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        s_c_d  = '1;
        s_hi_d = A;
`endif
        s_ovf_d = 1'b1;
      end
      OP_AND: s_c_d = A & B;
      OP_OR:  s_c_d = A | B;
      OP_XOR: s_c_d = A ^ B;
      OP_NOT: s_c_d = ~A;
      OP_EQ:  s_c_d = {{(WIDTH-1){1'b0}}, (A == B)};
      OP_GT:  s_c_d = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_LT:  s_c_d = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SHL: begin s_c_d = {A[WIDTH-2:0], 1'b0};       s_carry_d = A[WIDTH-1]; end
      OP_SHR: begin s_c_d = {1'b0, A[WIDTH-1:1]};       s_carry_d = A[0];       end
      OP_ROL: begin s_c_d = {A[WIDTH-2:0], A[WIDTH-1]}; s_carry_d = A[WIDTH-1]; end
      OP_ROR: begin s_c_d = {A[0], A[WIDTH-1:1]};       s_carry_d = A[0];       end
      OP_PAS: s_c_d = A;
      default: ;
    endcase
  end

  // One iteration: MUL shifts {hi,lo} right after a conditional add; DIV shifts left and trial-subtracts.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    step_hi_d = mul_sum[WIDTH:1];
    step_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (div_q) begin
      step_hi_d = trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : trial[WIDTH-1:0];
      step_lo_d = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      c_hi_q  <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (SEL == OP_MUL) begin
            hi_q    <= '0;
            lo_q    <= B;
            opnd_q  <= A;
            cnt_q   <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q   <= 1'b0;
`endif
            state_q <= BUSY;
          end
`ifdef ALU_SEQ_DIV_EN
          else if (SEL == OP_DIV && B != '0) begin
            hi_q    <= '0;
            lo_q    <= A;
            opnd_q  <= B;
            cnt_q   <= '0;
            div_q   <= 1'b1;
            state_q <= BUSY;
          end
`endif
          else begin
            c_q     <= s_c_d;
            c_hi_q  <= s_hi_d;
            zero_q  <= (s_c_d == '0);
            ovf_q   <= s_ovf_d;
            carry_q <= s_carry_d;
            state_q <= DONE;
          end
        end
        BUSY: begin
          hi_q  <= step_hi_d;
          lo_q  <= step_lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            c_q     <= step_lo_d;
            c_hi_q  <= step_hi_d;
            zero_q  <= (step_lo_d == '0);
`ifdef ALU_SEQ_DIV_EN
            ovf_q   <= !div_q && (step_hi_d != '0);
`else
            ovf_q   <= (step_hi_d != '0);
`endif
            carry_q <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized and directed bench for alu_seq_core (WIDTH=8) against an arithmetic reference model.
// Honours ALU_SEQ_DIV_EN for the expected DIV behaviour.
module tb_alu_seq_core;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   SEL = '0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] C, C_HI;
  logic         zero_flag, over_flow_flag, carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int c; int hi; bit z; bit o; bit cy; int lat; bit rb;
  } res_t;

  alu_seq_core #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .SEL(SEL),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .C_HI(C_HI), .zero_flag(zero_flag),
    .over_flow_flag(over_flow_flag), .carry_out(carry_out)
  );

  always #5 CLK = ~CLK;

  function automatic res_t model(int a, int b, int sel);
    res_t r;
    int sa, sb, t;
    r = '{default: 0};
    r.lat = 1;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (sel)
      0:  begin t = a + b; r.c = t % 256; r.cy = (t > 255); r.o = (sa + sb > 127) || (sa + sb < -128); end
      1:  begin r.c = (a - b + 256) % 256; r.cy = (a < b); r.o = (sa - sb > 127) || (sa - sb < -128); end
      2:  begin t = a * b; r.c = t % 256; r.hi = t / 256; r.o = (r.hi != 0); r.lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
      3:  if (b == 0) begin r.c = 255; r.hi = a; r.o = 1; end
          else begin r.c = a / b; r.hi = a % b; r.lat = W + 1; end
`else
      3:  begin r.c = 0; r.o = 1; end
`endif
      4:  r.c = a & b;
      5:  r.c = a | b;
      6:  r.c = a ^ b;
      7:  r.c = 255 - a;
      8:  r.c = (a == b) ? 1 : 0;
      9:  r.c = (a > b) ? 1 : 0;
      10: r.c = (a < b) ? 1 : 0;
      11: begin r.c = (a * 2) % 256; r.cy = (a >= 128); end
      12: begin r.c = a / 2; r.cy = (a % 2 == 1); end
      13: begin r.c = (a * 2) % 256 + a / 128; r.cy = (a >= 128); end
      14: begin r.c = a / 2 + (a % 2) * 128; r.cy = (a % 2 == 1); end
      default: r.c = a;
    endcase
    r.z = (r.c == 0);
    return r;
  endfunction

  // Issues one request, scrambles the inputs after acceptance, waits (bounded) for the result.
  task automatic run_txn(input int a, input int b, input int sel, output res_t r);
    int guard;
    r = '{default: 0};
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge CLK); #1; guard++; end
    A = W'(a); B = W'(b); SEL = 4'(sel); in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); SEL = 4'($urandom);
    r.lat = 1;
    while (!out_valid && r.lat < 40) begin
      if (in_ready) r.rb = 1'b1;
      @(posedge CLK); #1;
      r.lat++;
    end
    if (in_ready) r.rb = 1'b1;
    r.c = int'(C); r.hi = int'(C_HI); r.z = zero_flag; r.o = over_flow_flag; r.cy = carry_out;
    $display("txn sel=%0d a=%0d b=%0d -> C=%0d C_HI=%0d z=%0b v=%0b c=%0b lat=%0d",
             sel, a, b, r.c, r.hi, r.z, r.o, r.cy, r.lat);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (C !== '0 || C_HI !== '0) begin n_fail++; $display("FAIL reset_result got C=%0d C_HI=%0d want 0 0", C, C_HI); end
    n_checks++; if ({zero_flag, over_flow_flag, carry_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {zero_flag, over_flow_flag, carry_out}); end
    RST = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    res_t r;
    run_txn(255, 255, 0, r);
    n_checks++; if (r.c !== 254 || r.cy !== 1'b1 || r.o !== 1'b0) begin
      n_fail++; $display("FAIL add_255_255 got C=%0d c=%0b v=%0b want 254 1 0", r.c, r.cy, r.o); end
    n_checks++; if (r.lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d want 1", r.lat); end
    run_txn(127, 1, 0, r);
    n_checks++; if (r.c !== 128 || r.o !== 1'b1 || r.cy !== 1'b0) begin
      n_fail++; $display("FAIL add_127_1 got C=%0d v=%0b c=%0b want 128 1 0", r.c, r.o, r.cy); end
    run_txn(255, 1, 0, r);
    n_checks++; if (r.c !== 0 || r.z !== 1'b1 || r.cy !== 1'b1) begin
      n_fail++; $display("FAIL add_255_1 got C=%0d z=%0b c=%0b want 0 1 1", r.c, r.z, r.cy); end
    run_txn(200, 3, 2, r);
    n_checks++; if (r.c !== 88 || r.hi !== 2 || r.o !== 1'b1) begin
      n_fail++; $display("FAIL mul_200_3 got C=%0d C_HI=%0d v=%0b want 88 2 1", r.c, r.hi, r.o); end
    n_checks++; if (r.lat !== 9) begin n_fail++; $display("FAIL mul_latency got %0d want 9", r.lat); end
    n_checks++; if (r.rb !== 1'b0) begin n_fail++; $display("FAIL mul_in_ready got seen-high=%0b want 0", r.rb); end
`ifdef ALU_SEQ_DIV_EN
    run_txn(100, 7, 3, r);
    n_checks++; if (r.c !== 14 || r.hi !== 2 || r.lat !== 9) begin
      n_fail++; $display("FAIL div_100_7 got C=%0d C_HI=%0d lat=%0d want 14 2 9", r.c, r.hi, r.lat); end
    run_txn(9, 0, 3, r);
    n_checks++; if (r.c !== 255 || r.hi !== 9 || r.o !== 1'b1 || r.lat !== 1) begin
      n_fail++; $display("FAIL div_by_zero got C=%0d C_HI=%0d v=%0b lat=%0d want 255 9 1 1", r.c, r.hi, r.o, r.lat); end
`else
    run_txn(100, 7, 3, r);
    n_checks++; if (r.c !== 0 || r.hi !== 0 || r.o !== 1'b1 || r.z !== 1'b1 || r.lat !== 1) begin
      n_fail++; $display("FAIL div_disabled got C=%0d C_HI=%0d v=%0b z=%0b lat=%0d want 0 0 1 1 1",
                         r.c, r.hi, r.o, r.z, r.lat); end
`endif
  endtask

  task automatic test_random();
    res_t r, e;
    int a, b, sel;
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 15));
      a   = int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      if (i % 9 == 4) b = 0;
      if (i % 11 == 5) b = a;
      e = model(a, b, sel);
      run_txn(a, b, sel, r);
      n_checks++;
      if (r.c !== e.c || r.hi !== e.hi || r.z !== e.z || r.o !== e.o || r.cy !== e.cy || r.lat !== e.lat || r.rb !== 1'b0) begin
        n_fail++;
        $display("FAIL rand[%0d] sel=%0d a=%0d b=%0d got C=%0d HI=%0d z%0b v%0b c%0b lat%0d rb%0b want C=%0d HI=%0d z%0b v%0b c%0b lat%0d rb0",
                 i, sel, a, b, r.c, r.hi, r.z, r.o, r.cy, r.lat, r.rb, e.c, e.hi, e.z, e.o, e.cy, e.lat);
      end
    end
  endtask

  task automatic test_hold();
    int guard;
    A = 8'd10; B = 8'd20; SEL = 4'h0; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 10) begin @(posedge CLK); #1; guard++; end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_valid = 1'b1; A = 8'd1; B = 8'd1; SEL = 4'h0; end
      @(posedge CLK); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || C !== 8'd30 || C_HI !== 8'd0 ||
          {zero_flag, over_flow_flag, carry_out} !== 3'b000) begin
        n_fail++;
        $display("FAIL hold[%0d] got ov=%b ir=%b C=%0d HI=%0d flags=%b want 1 0 30 0 000",
                 i, out_valid, in_ready, C, C_HI, {zero_flag, over_flow_flag, carry_out});
      end
    end
    A = 8'd5; B = 8'd6; SEL = 4'h6; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_edge got ov=%b ir=%b want 0 1", out_valid, in_ready); end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || C !== 8'd3) begin
      n_fail++; $display("FAIL issue_after_release got ov=%b C=%0d want 1 3", out_valid, C); end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    res_t r;
    A = 8'd200; B = 8'd3; SEL = 4'h2; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || C !== '0 || C_HI !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_mul_reset got ov=%b C=%0d HI=%0d ir=%b want 0 0 0 1", out_valid, C, C_HI, in_ready); end
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL discarded_mul got ov=%b ir=%b want 0 1", out_valid, in_ready); end
    run_txn(3, 5, 1, r);
    n_checks++; if (r.c !== 254 || r.cy !== 1'b1 || r.lat !== 1) begin
      n_fail++; $display("FAIL sub_3_5 got C=%0d c=%0b lat=%0d want 254 1 1", r.c, r.cy, r.lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports A, B  input  WIDTH each  operands, unsigned unless stated.
REQ-005 SHALL have port SEL  input  4  opcode.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1) as the request handshake.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1) as the result handshake.
REQ-008 SHALL have ports C (output, WIDTH, result low word) and C_HI (output, WIDTH, MUL high word / DIV remainder, else 0).
REQ-009 SHALL have zero_flag, over_flow_flag and carry_out as 1-bit outputs.

Function
REQ-010 SHALL decode SEL as: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT A, 1000 EQ, 1001 GT, 1010 LT, 1011 SHL1, 1100 SHR1, 1101 ROL1, 1110 ROR1, 1111 PASS A.
REQ-011 SHALL use FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-012 SHALL capture A, B and SEL on the accept edge (in_valid && in_ready); input changes after acceptance SHALL be ignored.
REQ-013 SHALL handle single-cycle ops (all except MUL/DIV) as IDLE->DONE, with out_valid high 1 cycle after accept.
REQ-014 SHALL handle MUL as a shift-add: IDLE->BUSY, WIDTH iterations, then ->DONE; out_valid high WIDTH+1 cycles after accept; {C_HI,C} = A*B.
REQ-015 SHALL handle DIV as restoring division: WIDTH iterations; C = A/B, C_HI = A%B; same latency as MUL.
REQ-016 SHALL, for DIV with B==0, go directly to DONE (latency 1) with C = all ones, C_HI = A, over_flow_flag = 1.
REQ-017 SHALL remain in DONE with C, C_HI and flags stable until out_ready=1, then go to IDLE the following edge; out_ready=1 while out_valid=0 SHALL have no effect.
REQ-018 SHALL NOT accept a new request in the cycle of the DONE->IDLE transition; minimum issue interval is 2 cycles.
REQ-019 SHALL produce EQ/GT/LT as C = 1 if A==B / A>B / A<B, else 0.
REQ-020 SHALL set carry_out as: ADD = carry out of MSB; SUB = borrow (A<B); SHL1/ROL1 = old A MSB; SHR1/ROR1 = old A LSB; all other ops 0.
REQ-021 SHALL set over_flow_flag as: ADD/SUB = two's-complement signed overflow; MUL = (C_HI!=0); DIV = divide-by-zero; all other ops 0.
REQ-022 SHALL set zero_flag = (C==0) for every op, including MUL and DIV.
REQ-023 SHALL wrap ADD/SUB modulo 2^WIDTH.

Reset
REQ-024 SHALL, on RST=0 (any time, including mid-MUL/DIV), immediately force state=IDLE, clear C, C_HI and all flags to 0, drive out_valid=0, and discard any in-flight operation.
REQ-025 SHALL drive in_ready=1 during reset and on the first cycle after RST deasserts.

Configuration
REQ-026 SHALL compile the DIV datapath only when macro ALU_SEQ_DIV_EN is defined; otherwise SEL=0011 SHALL complete in 1 cycle with C=0, C_HI=0, zero_flag=1, over_flow_flag=1, and no divider logic SHALL be synthesised.

Verification
REQ-027 SHALL cover: WIDTH=8, ADD A=255 B=255 -> C=254, carry_out=1, over_flow_flag=0, out_valid 1 cycle after accept.
REQ-028 SHALL cover: ADD A=127 B=1 -> C=128, over_flow_flag=1, carry_out=0; then ADD A=255 B=1 -> C=0, zero_flag=1, carry_out=1.
REQ-029 SHALL cover: MUL A=200 B=3 -> C=88, C_HI=2, over_flow_flag=1, out_valid exactly 9 cycles after accept, in_ready=0 throughout.
REQ-030 SHALL cover: with ALU_SEQ_DIV_EN, DIV A=100 B=7 -> C=14, C_HI=2; DIV A=9 B=0 -> C=255, C_HI=9, over_flow_flag=1 after 1 cycle; without the macro, DIV -> C=0, over_flow_flag=1.
REQ-031 SHALL cover: out_ready held 0 for 10 cycles in DONE -> C and flags stable and in_ready=0; a new in_valid pulse during that time is not accepted.
REQ-032 SHALL cover: RST asserted at cycle 4 of a MUL -> out_valid=0 and C=0 immediately; after release, SUB A=3 B=5 -> C=254, carry_out=1.
